// File: rtl/lightspeed_pkg.sv
// Shared types and constants for the light-speed streak scheduler:
// FSM encoding, LFSR feedback taps and the coordinate width.
package lightspeed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_CRUISE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 (right-shifting)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          COORD_W   = 12;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = {1'b0, v[15:1]};
    if (v[0]) begin
      lfsr_next = shifted ^ LFSR_TAPS;
    end else begin
      lfsr_next = shifted;
    end
  endfunction

endpackage

// File: rtl/lightspeed_lfsr.sv
// 16-bit Galois LFSR used to pick the horizontal spawn position of streaks.
module lightspeed_lfsr
  import lightspeed_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_val
);

  // LFSR state register, advances only when enabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_val <= SEED;
    end else if (i_en) begin
      o_val <= lfsr_next(o_val);
    end else begin
      o_val <= o_val;
    end
  end

endmodule

// File: rtl/lightspeed_sched.sv
// Light-speed jump scheduler: ramps streak speed up and down, spawns streaks
// into free slots at random x positions and moves them down the display.
module lightspeed_sched
  import lightspeed_pkg::*;
#(
  parameter int          N_SLOTS   = 4,
  parameter int          D_WIDTH   = 640,
  parameter int          D_HEIGHT  = 480,
  parameter int          H_SIZE    = 8,
  parameter int          L_FACTOR  = 4,
  parameter int          SPAWN_GAP = 16,
  parameter int          MAX_SPEED = 8,
  parameter int          RAMP_DIV  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ani_stb,
  input  logic                   i_paused,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic [1:0]             o_state,
  output logic [3:0]             o_speed,
  output logic                   o_done,
  output logic [N_SLOTS-1:0]     o_active,
  output logic [12*N_SLOTS-1:0]  o_cx,
  output logic [12*N_SLOTS-1:0]  o_cy
);

  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int SW = $clog2(SPAWN_GAP + 1);
  localparam logic [COORD_W-1:0] CY_SPAWN = COORD_W'(L_FACTOR * H_SIZE);
  localparam logic [COORD_W-1:0] CY_EXIT  = COORD_W'(D_HEIGHT + L_FACTOR * H_SIZE);
  localparam logic [COORD_W-1:0] CX_WRAP  = COORD_W'(D_WIDTH - H_SIZE);
  localparam logic [COORD_W-1:0] CX_SUB   = COORD_W'(D_WIDTH - 2 * H_SIZE);

  state_t               state_r, state_nxt;
  logic [3:0]           speed_r, speed_nxt;
  logic [RW-1:0]        ramp_r, ramp_nxt;
  logic [SW-1:0]        spawn_r, spawn_nxt;
  logic                 done_r, done_nxt;
  logic                 tick, step_due, spawn_en, any_free;
  logic [N_SLOTS-1:0]   spawn_sel;
  logic [15:0]          lfsr_val;
  logic [COORD_W-1:0]   spawn_sum, spawn_cx;
  logic                 unused_lfsr_hi;

  assign tick     = i_ani_stb & ~i_paused;
  assign step_due = tick && (ramp_r == RW'(RAMP_DIV - 1));

  lightspeed_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (tick),
    .o_val   (lfsr_val)
  );

  assign unused_lfsr_hi = ^lfsr_val[15:10];
  assign spawn_sum      = COORD_W'(H_SIZE) + {2'b00, lfsr_val[9:0]};
  assign spawn_cx       = (spawn_sum >= CX_WRAP) ? (spawn_sum - CX_SUB) : spawn_sum;

  // Lowest-index free slot, judged before this tick's exits
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (!o_active[k] && !any_free) begin
        spawn_sel[k] = 1'b1;
        any_free     = 1'b1;
      end else begin
        spawn_sel[k] = 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start && !i_stop) state_nxt = ST_RAMP_UP;
        else                    state_nxt = ST_IDLE;
      end
      ST_RAMP_UP: begin
        if (i_stop)                                          state_nxt = ST_RAMP_DOWN;
        else if (step_due && (speed_r + 4'd1 == 4'(MAX_SPEED))) state_nxt = ST_CRUISE;
        else                                                 state_nxt = ST_RAMP_UP;
      end
      ST_CRUISE: begin
        if (i_stop) state_nxt = ST_RAMP_DOWN;
        else        state_nxt = ST_CRUISE;
      end
      ST_RAMP_DOWN: begin
        if (o_active == '0) state_nxt = ST_IDLE;
        else                state_nxt = ST_RAMP_DOWN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: speed, ramp/spawn counters and the done pulse
  always_comb begin
    speed_nxt = speed_r;
    ramp_nxt  = ramp_r;
    spawn_nxt = spawn_r;
    spawn_en  = 1'b0;
    done_nxt  = 1'b0;
    if (tick && (state_r == ST_RAMP_UP || state_r == ST_CRUISE)) begin
      if (spawn_r >= SW'(SPAWN_GAP - 1)) begin
        spawn_en  = any_free;
        spawn_nxt = any_free ? SW'(0) : SW'(SPAWN_GAP);
      end else begin
        spawn_nxt = spawn_r + SW'(1);
      end
    end else begin
      spawn_nxt = spawn_r;
    end
    case (state_r)
      ST_IDLE: begin
        speed_nxt = 4'd0;
        if (i_start && !i_stop) begin
          speed_nxt = 4'd1;
          ramp_nxt  = '0;
          spawn_nxt = '0;
        end else begin
          ramp_nxt  = ramp_r;
        end
      end
      ST_RAMP_UP, ST_CRUISE: begin
        if (i_stop) begin
          ramp_nxt = '0;
        end else if (state_r == ST_RAMP_UP && step_due) begin
          ramp_nxt  = '0;
          speed_nxt = speed_r + 4'd1;
        end else if (state_r == ST_RAMP_UP && tick) begin
          ramp_nxt = ramp_r + RW'(1);
        end else begin
          ramp_nxt = ramp_r;
        end
      end
      ST_RAMP_DOWN: begin
        if (o_active == '0) begin
          speed_nxt = 4'd0;
          ramp_nxt  = '0;
          done_nxt  = 1'b1;
        end else if (step_due) begin
          ramp_nxt  = '0;
          speed_nxt = (speed_r > 4'd1) ? (speed_r - 4'd1) : 4'd1;
        end else if (tick) begin
          ramp_nxt = ramp_r + RW'(1);
        end else begin
          ramp_nxt = ramp_r;
        end
      end
      default: begin
        speed_nxt = 4'd0;
        ramp_nxt  = '0;
      end
    endcase
  end

  // Speed, counters and done pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      speed_r <= 4'd0;
      ramp_r  <= '0;
      spawn_r <= '0;
      done_r  <= 1'b0;
    end else begin
      speed_r <= speed_nxt;
      ramp_r  <= ramp_nxt;
      spawn_r <= spawn_nxt;
      done_r  <= done_nxt;
    end
  end

  assign o_state = state_r;
  assign o_speed = speed_r;
  assign o_done  = done_r;

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
    logic               active_r;
    logic [COORD_W-1:0] cx_r, cy_r, cy_move;

    assign cy_move = cy_r + {{(COORD_W-4){1'b0}}, speed_r};

    // Slot position: spawn, fall by the current speed, retire past the bottom
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        active_r <= 1'b0;
        cx_r     <= '0;
        cy_r     <= '0;
      end else if (spawn_en && spawn_sel[k]) begin
        active_r <= 1'b1;
        cx_r     <= spawn_cx;
        cy_r     <= CY_SPAWN;
      end else if (tick && active_r) begin
        active_r <= (cy_move < CY_EXIT);
        cy_r     <= cy_move;
      end else begin
        active_r <= active_r;
        cy_r     <= cy_r;
      end
    end

    assign o_active[k]           = active_r;
    assign o_cx[12*k +: 12]      = cx_r;
    assign o_cy[12*k +: 12]      = cy_r;
  end

endmodule

// File: tb/tb_lightspeed_sched.sv
// Randomised self-checking bench for lightspeed_sched against a rule-level model.
module tb_lightspeed_sched;

  localparam int N = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_ani_stb = 1'b0, i_paused = 1'b0, i_start = 1'b0, i_stop = 1'b0;
  logic [1:0]      o_state;
  logic [3:0]      o_speed;
  logic            o_done;
  logic [N-1:0]    o_active;
  logic [12*N-1:0] o_cx, o_cy;

  lightspeed_sched #(
    .N_SLOTS(4), .D_WIDTH(640), .D_HEIGHT(480), .H_SIZE(8), .L_FACTOR(4),
    .SPAWN_GAP(16), .MAX_SPEED(8), .RAMP_DIV(4), .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ani_stb(i_ani_stb), .i_paused(i_paused),
    .i_start(i_start), .i_stop(i_stop), .o_state(o_state), .o_speed(o_speed),
    .o_done(o_done), .o_active(o_active), .o_cx(o_cx), .o_cy(o_cy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;

  // Model state: plain integers following the jump rules
  int          m_state, m_speed, m_ramp, m_spawn, m_done;
  logic [15:0] m_lfsr;
  int          m_act[N], m_cx[N], m_cy[N];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_lfsr_adv(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int spawn_x(input logic [15:0] v);
    int s;
    s = 8 + int'(v & 16'h03FF);
    if (s >= 632) s = s - 624;
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_ramp = 0; m_spawn = 0; m_done = 0;
    m_lfsr = 16'hACE1;
    for (int k = 0; k < N; k++) begin
      m_act[k] = 0; m_cx[k] = 0; m_cy[k] = 0;
    end
  endtask

  task automatic model_step(input logic stb, input logic paused, input logic start, input logic stop);
    bit tick;
    int free_k;
    bit all_idle;
    tick = stb && !paused;
    free_k = -1;
    all_idle = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (m_act[k] != 0) all_idle = 1'b0;
      else if (free_k < 0) free_k = k;
    end
    m_done = 0;
    if (tick) begin
      for (int k = 0; k < N; k++) begin
        if (m_act[k] != 0) begin
          m_cy[k] = m_cy[k] + m_speed;
          if (m_cy[k] >= 512) m_act[k] = 0;
        end
      end
    end
    if (tick && (m_state == 1 || m_state == 2)) begin
      m_spawn = (m_spawn + 1 > 16) ? 16 : m_spawn + 1;
      if (m_spawn == 16 && free_k >= 0) begin
        m_act[free_k] = 1;
        m_cy[free_k]  = 32;
        m_cx[free_k]  = spawn_x(m_lfsr);
        m_spawn       = 0;
      end
    end
    case (m_state)
      0: begin
        m_speed = 0;
        if (start && !stop) begin
          m_state = 1; m_speed = 1; m_ramp = 0; m_spawn = 0;
        end
      end
      1, 2: begin
        if (stop) begin
          m_state = 3; m_ramp = 0;
        end else if (m_state == 1 && tick) begin
          m_ramp++;
          if (m_ramp == 4) begin
            m_ramp = 0;
            m_speed++;
            if (m_speed == 8) m_state = 2;
          end
        end
      end
      default: begin
        if (all_idle) begin
          m_state = 0; m_speed = 0; m_done = 1; m_ramp = 0;
        end else if (tick) begin
          m_ramp++;
          if (m_ramp == 4) begin
            m_ramp = 0;
            if (m_speed > 1) m_speed--;
          end
        end
      end
    endcase
    if (tick) m_lfsr = m_lfsr_adv(m_lfsr);
  endtask

  task automatic compare_all();
    chk("state", int'(o_state), m_state);
    chk("speed", int'(o_speed), m_speed);
    chk("done",  int'(o_done),  m_done);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("active[%0d]", k), int'(o_active[k]), m_act[k]);
      chk($sformatf("cx[%0d]", k), int'(o_cx[12*k +: 12]), m_cx[k]);
      chk($sformatf("cy[%0d]", k), int'(o_cy[12*k +: 12]), m_cy[k]);
    end
  endtask

  task automatic step(input logic stb, input logic paused, input logic start, input logic stop);
    i_ani_stb = stb; i_paused = paused; i_start = start; i_stop = stop;
    @(posedge i_clk);
    model_step(stb, paused, start, stop);
    #1;
    compare_all();
    if (o_done) done_pulses++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    model_reset();
    #12;
    compare_all();
    chk("lfsr_reset", int'(dut.u_lfsr.o_val), 32'hACE1);
    i_rst_n = 1'b1;

    // Jump start and ramp-up
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("start_state", int'(o_state), 1);
    chk("start_speed", int'(o_speed), 1);
    for (t = 1; t <= 36; t++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (t == 1)  chk("lfsr_first_tick", int'(dut.u_lfsr.o_val), 32'hE270);
      if (t == 16) begin
        chk("spawn0_active", int'(o_active[0]), 1);
        chk("spawn0_cy", int'(o_cy[11:0]), 32);
        chk("spawn0_cx_range", int'(o_cx[11:0] >= 12'd8 && o_cx[11:0] <= 12'd631), 1);
        chk("spawn0_only", int'(o_active), 1);
      end
      if (t == 28) begin
        chk("cruise_state", int'(o_state), 2);
        chk("cruise_speed", int'(o_speed), 8);
      end
      if (t == 32) begin
        chk("spawn1_active", int'(o_active[1]), 1);
        chk("spawn1_cy", int'(o_cy[23:12]), 32);
      end
    end

    // Randomised cruise: strobes, pauses and ignored start requests
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 19) == 0), 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Exit request and ramp-down
    done_pulses = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("stop_state", int'(o_state), 3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rampdown_speed7", int'(o_speed), 7);
    for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rampdown_floor", int'(o_speed), 1);
    t = 0;
    while (o_state != 2'd0 && t < 2000) begin
      step(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
      t++;
    end
    chk("idle_reached", int'(o_state), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_pulses", done_pulses, 1);

    // Start and stop together in IDLE
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("start_stop_idle", int'(o_state), 0);

    // Asynchronous reset in the middle of ramp-up
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    done_pulses = 0;
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_lfsr", int'(dut.u_lfsr.o_val), 32'hACE1);
    chk("rst_outputs_zero", int'(o_active != '0 || o_cx != '0 || o_cy != '0 || o_speed != 4'd0), 0);
    @(posedge i_clk);
    #1;
    compare_all();
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_no_done", done_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lightspeed_sched.md
LIGHTSPEED_SCHED -- requirements
Module: lightspeed_sched

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of light-streak slots.
REQ-002 SHALL have parameter D_WIDTH, default 640, display width in pixels.
REQ-003 SHALL have parameter D_HEIGHT, default 480, display height in pixels.
REQ-004 SHALL have parameter H_SIZE, default 8, streak half-width.
REQ-005 SHALL have parameter L_FACTOR, default 4, streak half-length = L_FACTOR*H_SIZE.
REQ-006 SHALL have parameter SPAWN_GAP, default 16, ticks between spawns.
REQ-007 SHALL have parameter MAX_SPEED, default 8, cruise speed in pixels/tick (4-bit).
REQ-008 SHALL have parameter RAMP_DIV, default 4, ticks per speed step.
REQ-009 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value.
REQ-010 SHALL have one clock and an asynchronous active-low reset, listed first: i_clk input 1 base clock; i_rst_n input 1 asynchronous active-low reset.
REQ-011 i_ani_stb input 1 animation strobe; i_paused input 1 pause level; i_start input 1 jump request; i_stop input 1 exit request.
REQ-012 o_state output 2 FSM state; o_speed output 4 current speed; o_done output 1 one-cycle pulse on return to IDLE.
REQ-013 o_active output N_SLOTS slot-valid flags; o_cx output 12*N_SLOTS streak centre x; o_cy output 12*N_SLOTS streak centre y (slot k at bits [12k+11:12k]).

Function
REQ-014 A "tick" SHALL be a cycle with i_ani_stb=1 and i_paused=0; only ticks advance speed, spawn counter, ramp counter, LFSR and positions.
REQ-015 States SHALL be IDLE=0, RAMP_UP=1, CRUISE=2, RAMP_DOWN=3, and the FSM SHALL evaluate transitions every cycle.
REQ-016 IDLE: speed 0, no spawns; i_start=1 and i_stop=0 -> RAMP_UP next cycle with speed=1, ramp and spawn counters cleared; i_start and i_stop together -> stay IDLE.
REQ-017 RAMP_UP: speed increments every RAMP_DIV ticks; the tick that sets speed to MAX_SPEED moves the FSM to CRUISE.
REQ-018 RAMP_UP or CRUISE with i_stop=1 (any cycle) -> RAMP_DOWN next cycle, ramp counter cleared.
REQ-019 RAMP_DOWN: speed decrements every RAMP_DIV ticks, saturating at 1; no spawns; i_start ignored.
REQ-020 RAMP_DOWN with all o_active=0 -> IDLE next cycle, speed 0, o_done=1 for exactly that cycle.
REQ-021 Spawn counter SHALL count ticks in RAMP_UP/CRUISE; on the tick it reaches SPAWN_GAP it spawns into the lowest-index free slot and clears; with no free slot it saturates and spawns on the first tick a slot is free.
REQ-022 Spawned slot: active=1, cy=L_FACTOR*H_SIZE, cx=H_SIZE+lfsr[9:0], minus (D_WIDTH-2*H_SIZE) if that sum >= D_WIDTH-H_SIZE.
REQ-023 LFSR SHALL be 16-bit Galois, taps x^16+x^14+x^13+x^11, advancing every tick in every state.
REQ-024 Each tick, every active slot SHALL update cy <= cy+speed; if the new cy >= D_HEIGHT+L_FACTOR*H_SIZE the slot clears active and holds that cy.
REQ-025 A slot freed on a tick SHALL NOT be spawned into on the same tick.
REQ-026 Inactive slots SHALL hold last cx/cy; all arithmetic is 12-bit unsigned, no overflow within defaults.

Reset
REQ-027 On i_rst_n=0, asynchronously: state IDLE, speed 0, counters 0, LFSR=LFSR_SEED, all o_active=0, o_cx=0, o_cy=0, o_done=0.
REQ-028 Reset asserted mid-jump SHALL abort immediately with no o_done pulse.

Structure
REQ-029 Package lightspeed_pkg SHALL hold the state enum, LFSR tap constant and the 12-bit coordinate width.
REQ-030 LFSR SHALL be sub-module lightspeed_lfsr (ports i_clk, i_rst_n, i_en, o_val[15:0]); slots generated per index.

Verification
REQ-031 i_start pulse, continuous ticks -> o_state=1, speed 1; speed=8 and o_state=2 after 28 ticks.
REQ-032 Start, 16 ticks -> o_active[0]=1, o_cy[0]=32, o_cx[0] in [8,631]; next spawn is slot 1, 16 ticks later.
REQ-033 Cruise at speed 8, slot cy=504 -> next tick cy=512, o_active cleared; slot not respawned on that tick.
REQ-034 i_stop in CRUISE -> RAMP_DOWN, speed 7 after 4 ticks, floor 1; after last slot exits -> IDLE, single o_done pulse.
REQ-035 i_paused=1 with strobes -> speed, positions and LFSR frozen; i_start and i_stop together in IDLE -> stays IDLE.
REQ-036 i_rst_n low mid-RAMP_UP -> all outputs 0 asynchronously, LFSR=16'hACE1, no o_done.
